wdpckr_input_ctrl: RTL
======================

// Module: wdpckr_input_ctrl
// PURPOSE
//  Input conditioner directly upstream of the pacman core's in0/in1 ports. Decodes PS/2 key
//  events and merges them with both joysticks; remaps directions for Horz orientation.
//  Synthesises a timed coin pulse from Start presses and delivers active-low in0/in1 words.
//  Replaces the inline key decode and combinational coin generation in the top level.
// PARAMETERS
//  COIN_FRAMES      4  vblank rising edges the coin bit stays asserted
//  GAP_FRAMES       8  vblank rising edges between coin release and Start release
//  AUTOFIRE_FRAMES  3  vblank rising edges per autofire half-period (AUTOFIRE_EN only)
// PORTS
//  CLK          in   1   clk_sys; all logic on rising edge
//  RESET_N      in   1   asynchronous, active-low reset
//  ps2_key      in   65  hps_io key event; bit64 toggles per event
//  joystick_0   in   16  [0]R [1]L [2]D [3]U [4]Fire [5]Start1 [6]Start2 [7]Skip
//  joystick_1   in   16  same map; OR-ed with joystick_0
//  rotate       in   1   status[2]: 1 = Horz, directions remapped
//  vblank       in   1   core O_VBLANK; rising edge = one frame tick
//  autofire_on  in   1   autofire enable; ignored when AUTOFIRE_EN undefined
//  in0          out  8   ~{2'b00,coin,skip,down,right,left,up}
//  in1          out  8   ~{1'b0,start2,start1,fire,4'b0000}
// BEHAVIOUR
//  Reset: in0=8'hFF, in1=8'hFF; all key latches 0; FSM IDLE; frame counter 0; vblank history 0.
//  Key decode: event = ps2_key[64] != registered copy. pressed = ps2_key[15:8]!=8'hF0;
//   extended = pressed ? ps2_key[15:8]==8'hE0 : ps2_key[23:16]==8'hE0; ps2_key[63:24]!=0 -> code 0.
//   Codes: X75 up, X72 down, X6B left, X74 right (X = either extended bit), 029/014 fire,
//   005 start1, 006 start2, 003 skip. Latch <= pressed on the event cycle; other codes ignored.
//  Merge: btn = key latch | joystick_0 bit | joystick_1 bit.
//  Rotate=1: up<-L, down<-R, left<-D, right<-U (key and joy alike); rotate=0 straight.
//  Frame tick: one-cycle pulse on vblank 0->1 (registered edge detect).
//  Coin FSM (start_any = start1|start2):
//   IDLE:  start_any rising edge -> COIN, counter=0.
//   COIN:  coin=1; count ticks; at COIN_FRAMES -> GAP, counter=0.
//   GAP:   coin=0; count ticks; at GAP_FRAMES -> HOLD.
//   HOLD:  start bits pass through; start_any==0 -> IDLE.
//  Start bits in in1 are forced 0 in COIN and GAP; passed through in IDLE and HOLD.
//  Start re-press while in COIN/GAP is ignored (no second coin); a fresh coin needs release.
//  Tick and transition on same cycle: the tick counts toward the current state's total first.
//  Counters saturate, never wrap; widths sized by $clog2 of the largest parameter + 1.
//  Latency: key event -> in0/in1 change = 2 CLK (latch, then output register).
//  Joystick change -> in0/in1 = 1 CLK. rotate change takes effect on the next output register.
//  RESET_N low mid-coin: immediately IDLE, outputs 8'hFF; held Start after release needs a new edge.
// CONFIGURATION
//  AUTOFIRE_EN defined: autofire_on=1 with fire held -> fire bit toggles every AUTOFIRE_FRAMES
//   ticks, starting asserted; fire release or autofire_on=0 -> phase and counter cleared, plain fire.
//  AUTOFIRE_EN undefined: fire bit = merged fire; autofire_on unused; no autofire counter logic.
// TESTING
//  T1 reset: RESET_N=0 with joystick_0=16'hFFFF -> in0=8'hFF, in1=8'hFF; release -> joy seen in 1 CLK.
//  T2 key: ps2_key={~bit64,...,8'h00,8'hE0,8'h75} -> in0=8'hFE after 2 CLK; F0 release -> 8'hFF.
//  T3 rotate: rotate=1, joystick_0[1]=1 (L) -> in0=8'hFE (up); rotate=0 -> in0=8'hFD (left).
//  T4 coin: Start1 held, 20 vblank pulses -> in0[5]=0 for exactly 4 ticks, then in1 stays 8'hFF
//   for 8 more ticks, then in1=8'hDF until release.
//  T5 re-press: Start1 released/re-pressed during GAP -> no second coin pulse; after HOLD+release
//   a new press gives a new 4-tick coin.
//  T6 AUTOFIRE_EN: autofire_on=1, fire held 12 ticks -> in1[4] pattern 0,0,0,1,1,1,0,0,0,1,1,1.

Source files
------------

// File: rtl/wdpckr_input_ctrl.sv
// wdpckr_input_ctrl: input conditioner in front of the pacman core's in0/in1 ports.
// Decodes PS/2 key events into held-key latches, ORs them with both joysticks, remaps
// directions for the Horz orientation and generates a timed coin pulse from Start presses.
// Outputs are registered, active-low words.
//
// Optional feature: define AUTOFIRE_EN to enable frame-timed autofire on the fire bit.
//
// Ports:
//   CLK         clk_sys, all logic on rising edge
//   RESET_N     asynchronous active-low reset
//   ps2_key     hps_io key event, bit 64 toggles once per event
//   joystick_0  [0]R [1]L [2]D [3]U [4]Fire [5]Start1 [6]Start2 [7]Skip
//   joystick_1  same map, OR-ed with joystick_0
//   rotate      1 = Horz orientation, directions remapped
//   vblank      frame strobe, each rising edge is one frame tick
//   autofire_on autofire enable (only used with AUTOFIRE_EN)
//   in0         ~{2'b00, coin, skip, down, right, left, up}
//   in1         ~{1'b0, start2, start1, fire, 4'b0000}
module wdpckr_input_ctrl #(
  parameter int unsigned COIN_FRAMES     = 4,
  parameter int unsigned GAP_FRAMES      = 8,
  parameter int unsigned AUTOFIRE_FRAMES = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [64:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        vblank,
  input  logic        autofire_on,
  output logic [7:0]  in0,
  output logic [7:0]  in1
);

  localparam int unsigned MaxCoinGap = (COIN_FRAMES > GAP_FRAMES) ? COIN_FRAMES : GAP_FRAMES;
  localparam int unsigned MaxFrames  = (MaxCoinGap > AUTOFIRE_FRAMES) ? MaxCoinGap :
                                                                         AUTOFIRE_FRAMES;
  localparam int unsigned CntW = $clog2(MaxFrames + 1);
  localparam logic [CntW-1:0] CoinLimit = CntW'(COIN_FRAMES);
  localparam logic [CntW-1:0] GapLimit  = CntW'(GAP_FRAMES);

  // Key latch indices
  localparam int unsigned KUp     = 0;
  localparam int unsigned KDown   = 1;
  localparam int unsigned KLeft   = 2;
  localparam int unsigned KRight  = 3;
  localparam int unsigned KFire   = 4;
  localparam int unsigned KStart1 = 5;
  localparam int unsigned KStart2 = 6;
  localparam int unsigned KSkip   = 7;

  typedef enum logic [1:0] {StIdle, StCoin, StGap, StHold} coin_st_e;

  logic            key_toggle_q;
  logic [7:0]      keys_q, keys_d;
  logic            vblank_q;
  logic            start_q;
  coin_st_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]      in0_q, in0_d, in1_q, in1_d;

  logic       key_event, key_pressed, key_ext;
  logic [7:0] key_code;
  logic [15:0] joy;
  logic raw_u, raw_d, raw_l, raw_r, fire_raw, start1, start2, skip;
  logic up, down, left, right, fire;
  logic tick, start_any, coin, start_mask;

  // PS/2 decode
  assign key_event   = ps2_key[64] != key_toggle_q;
  assign key_pressed = ps2_key[15:8] != 8'hF0;
  assign key_ext     = key_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
  // Events carrying anything in the upper bytes are not plain key codes
  assign key_code    = (|ps2_key[63:24]) ? 8'h00 : ps2_key[7:0];

  always_comb begin
    keys_d = keys_q;
    if (key_event) begin
      case ({key_ext, key_code})
        9'h075, 9'h175: keys_d[KUp]     = key_pressed;
        9'h072, 9'h172: keys_d[KDown]   = key_pressed;
        9'h06B, 9'h16B: keys_d[KLeft]   = key_pressed;
        9'h074, 9'h174: keys_d[KRight]  = key_pressed;
        9'h029, 9'h014: keys_d[KFire]   = key_pressed;
        9'h005:         keys_d[KStart1] = key_pressed;
        9'h006:         keys_d[KStart2] = key_pressed;
        9'h003:         keys_d[KSkip]   = key_pressed;
        default:        ;
      endcase
    end
  end

  // Merge keys with both joysticks, then apply orientation
  assign joy      = joystick_0 | joystick_1;
  assign raw_r    = keys_q[KRight]  | joy[0];
  assign raw_l    = keys_q[KLeft]   | joy[1];
  assign raw_d    = keys_q[KDown]   | joy[2];
  assign raw_u    = keys_q[KUp]     | joy[3];
  assign fire_raw = keys_q[KFire]   | joy[4];
  assign start1   = keys_q[KStart1] | joy[5];
  assign start2   = keys_q[KStart2] | joy[6];
  assign skip     = keys_q[KSkip]   | joy[7];

  assign up    = rotate ? raw_l : raw_u;
  assign down  = rotate ? raw_r : raw_d;
  assign left  = rotate ? raw_d : raw_l;
  assign right = rotate ? raw_u : raw_r;

  assign tick      = vblank & ~vblank_q;
  assign start_any = start1 | start2;

  // Coin sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      StIdle: begin
        if (start_any && !start_q) begin
          state_d = StCoin;
          cnt_d   = '0;
        end
      end
      StCoin: begin
        if (tick) begin
          if (cnt_inc >= CoinLimit) begin
            state_d = StGap;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (cnt_inc >= GapLimit) begin
            state_d = StHold;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StHold: begin
        if (!start_any) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded from the next state so the output register tracks the sequencer with no lag
  assign coin       = state_d == StCoin;
  assign start_mask = (state_d == StCoin) || (state_d == StGap);

`ifdef AUTOFIRE_EN
  localparam int unsigned AfW = $clog2(AUTOFIRE_FRAMES + 1);
  localparam logic [AfW-1:0] AfLimit = AfW'(AUTOFIRE_FRAMES);

  logic           af_phase_q, af_phase_d;
  logic [AfW-1:0] af_cnt_q, af_cnt_d, af_inc;

  assign af_inc = af_cnt_q + 1'b1;

  always_comb begin
    af_cnt_d   = af_cnt_q;
    af_phase_d = af_phase_q;
    if (autofire_on && fire_raw) begin
      if (tick) begin
        if (af_inc >= AfLimit) begin
          af_cnt_d   = '0;
          af_phase_d = ~af_phase_q;
        end else begin
          af_cnt_d = af_inc;
        end
      end
    end else begin
      af_cnt_d   = '0;
      af_phase_d = 1'b0;
    end
  end

  assign fire = fire_raw & ~af_phase_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b0;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end
`else
  logic unused_autofire;
  assign unused_autofire = autofire_on;
  assign fire = fire_raw;
`endif

  assign in0_d = ~{2'b00, coin, skip, down, right, left, up};
  assign in1_d = ~{1'b0, start2 & ~start_mask, start1 & ~start_mask, fire, 4'b0000};

  // start_q resets high so a Start held through reset does not count as a fresh press
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      key_toggle_q <= 1'b0;
      keys_q       <= '0;
      vblank_q     <= 1'b0;
      start_q      <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= '0;
      in0_q        <= 8'hFF;
      in1_q        <= 8'hFF;
    end else begin
      key_toggle_q <= ps2_key[64];
      keys_q       <= keys_d;
      vblank_q     <= vblank;
      start_q      <= start_any;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in0_q        <= in0_d;
      in1_q        <= in1_d;
    end
  end

  assign in0 = in0_q;
  assign in1 = in1_q;

endmodule
